// File: rtl/countdown_timer.sv
// ----------------------------------------------------------------------------
// countdown_timer
//   Bomb game countdown. Holds the remaining time MM:SS as four BCD digits and
//   counts down once per tick_1sec. Strikes queue extra seconds in a pending
//   penalty that is drained one second per clock. Raises warn/blink near zero
//   and reports expiry or defuse to the game FSM.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   tick_1sec, tick_10ms     one-clock timebase pulses from the tick generator
//   start, pause, defuse     control pulses (priority defuse > pause > start)
//   strike                   adds PENALTY_SEC to the pending penalty (RUN only)
//   min_tens..sec_ones       remaining time, BCD
//   running/expired/defused  state levels
//   expire_pulse             one clock on entry to EXPIRED
//   warn, blink              low-time warning and its blink phase
// ----------------------------------------------------------------------------
module countdown_timer #(
    parameter int unsigned INIT_MIN    = 5,
    parameter int unsigned INIT_SEC    = 0,
    parameter int unsigned PENALTY_SEC = 10,
    parameter int unsigned WARN_SEC    = 10,
    parameter int unsigned BLINK_HALF  = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1sec,
    input  logic       tick_10ms,
    input  logic       start,
    input  logic       pause,
    input  logic       defuse,
    input  logic       strike,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse,
    output logic       defused,
    output logic       warn,
    output logic       blink
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED,
        S_DEFUSED
    } state_t;

    localparam logic [15:0] INIT_BCD = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10),
                                        4'(INIT_SEC / 10), 4'(INIT_SEC % 10)};
    localparam logic [8:0]  PEN      = 9'(PENALTY_SEC);
    localparam int unsigned BW       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_digits;
    logic [15:0]     w_digits_nxt;
    logic [15:0]     w_dec_val;
    logic [8:0]      r_pend;
    logic [8:0]      w_pend_nxt;
    logic [9:0]      w_pend_sum;
    logic [9:0]      w_pend_add;
    logic [9:0]      w_pend_sub;
    logic            w_zero;
    logic            w_dec_req;
    logic [12:0]     w_total;
    logic            w_warn_nxt;
    logic            r_running;
    logic            r_expired;
    logic            r_expire_pulse;
    logic            r_defused;
    logic            r_warn;
    logic            r_blink;
    logic [BW-1:0]   r_blink_cnt;

    // One-second BCD decrement with borrow; caller guarantees value != 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_digits_nxt = r_digits;
        w_pend_nxt   = r_pend;
        w_zero       = (r_digits == '0);
        w_dec_req    = (tick_1sec || (r_pend != '0)) && !w_zero;
        w_dec_val    = bcd_dec(r_digits);
        // A tick cycle consumes the tick itself; pend only drains on tickless cycles.
        w_pend_add   = strike ? {1'b0, PEN} : '0;
        w_pend_sub   = (w_dec_req && !tick_1sec) ? 10'd1 : 10'd0;
        w_pend_sum   = {1'b0, r_pend} + w_pend_add - w_pend_sub;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_RUN;
                    w_digits_nxt = INIT_BCD;
                    w_pend_nxt   = '0;
                end
            end
            S_RUN: begin
                if (defuse) begin
                    // A decrement in the defuse cycle still lands, so a race
                    // with the final second shows 00:00 but reports DEFUSED.
                    w_state_nxt = S_DEFUSED;
                    w_pend_nxt  = '0;
                    if (w_dec_req) begin
                        w_digits_nxt = w_dec_val;
                    end
                end else if (pause) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_zero) begin
                    // Only reachable when loaded with 00:00.
                    w_state_nxt = S_EXPIRED;
                    w_pend_nxt  = '0;
                end else begin
                    w_pend_nxt = w_pend_sum[9] ? 9'h1FF : w_pend_sum[8:0];
                    if (w_dec_req) begin
                        w_digits_nxt = w_dec_val;
                        if (w_dec_val == '0) begin
                            w_state_nxt = S_EXPIRED;
                            w_pend_nxt  = '0;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (defuse) begin
                    w_state_nxt = S_DEFUSED;
                    w_pend_nxt  = '0;
                end else if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
            end
        endcase

        w_total = 13'(w_digits_nxt[15:12]) * 13'd600 + 13'(w_digits_nxt[11:8]) * 13'd60
                + 13'(w_digits_nxt[7:4]) * 13'd10 + 13'(w_digits_nxt[3:0]);
        w_warn_nxt = (w_state_nxt == S_RUN) && (32'(w_total) <= WARN_SEC);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_digits       <= INIT_BCD;
            r_pend         <= '0;
            r_running      <= 1'b0;
            r_expired      <= 1'b0;
            r_expire_pulse <= 1'b0;
            r_defused      <= 1'b0;
            r_warn         <= 1'b0;
            r_blink        <= 1'b0;
            r_blink_cnt    <= '0;
        end else begin
            r_digits       <= w_digits_nxt;
            r_pend         <= w_pend_nxt;
            r_running      <= (w_state_nxt == S_RUN);
            r_expired      <= (w_state_nxt == S_EXPIRED);
            r_expire_pulse <= (w_state_nxt == S_EXPIRED) && (r_state != S_EXPIRED);
            r_defused      <= (w_state_nxt == S_DEFUSED);
            r_warn         <= w_warn_nxt;
            // Only pulses seen while warn is already high count toward a toggle.
            if (!w_warn_nxt) begin
                r_blink_cnt <= '0;
                r_blink     <= 1'b0;
            end else if (r_warn && tick_10ms) begin
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} = r_digits;
    assign running      = r_running;
    assign expired      = r_expired;
    assign expire_pulse = r_expire_pulse;
    assign defused      = r_defused;
    assign warn         = r_warn;
    assign blink        = r_blink;

endmodule

// File: tb/tb_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_countdown_timer
//   Directed bench for countdown_timer with default parameters (05:00 load,
//   10 s penalty, warn at <= 10 s, 25-pulse blink half period). Expected
//   outputs are queued as each step is driven and compared after the edge.
// ----------------------------------------------------------------------------
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1sec, tick_10ms, start, pause, defuse, strike;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, expired, expire_pulse, defused, warn, blink;

    logic [21:0] w_obs;
    logic [21:0] exp_q[$];
    string       tag_q[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Flag order: {running, expired, expire_pulse, defused, warn, blink}
    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_RUN   = 6'b100000;
    localparam logic [5:0] F_RUNW  = 6'b100010;
    localparam logic [5:0] F_RUNWB = 6'b100011;
    localparam logic [5:0] F_EXP1  = 6'b011000;
    localparam logic [5:0] F_EXP   = 6'b010000;
    localparam logic [5:0] F_DEF   = 6'b000100;

    countdown_timer #(
        .INIT_MIN   (5),
        .INIT_SEC   (0),
        .PENALTY_SEC(10),
        .WARN_SEC   (10),
        .BLINK_HALF (25)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1sec   (tick_1sec),
        .tick_10ms   (tick_10ms),
        .start       (start),
        .pause       (pause),
        .defuse      (defuse),
        .strike      (strike),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .expired     (expired),
        .expire_pulse(expire_pulse),
        .defused     (defused),
        .warn        (warn),
        .blink       (blink)
    );

    always #5 clk = ~clk;

    assign w_obs = {min_tens, min_ones, sec_tens, sec_ones,
                    running, expired, expire_pulse, defused, warn, blink};

    function automatic logic [21:0] mk(input logic [3:0] mt, input logic [3:0] mo,
                                       input logic [3:0] st, input logic [3:0] so,
                                       input logic [5:0] f);
        return {mt, mo, st, so, f};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [21:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        logic [21:0] e;
        string       t;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h required <queued value>", w_obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (w_obs === e) n_pass++;
            else $error("FAIL %s: observed %h required %h", t, w_obs, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        {tick_1sec, tick_10ms, start, pause, defuse, strike} = '0;
        repeat (2) cyc();
        push("reset", mk(0, 5, 0, 0, F_NONE));
        check_out();
        rst = 1'b1;
        cyc();

        // Start and first tick
        start = 1'b1; push("t1_start", mk(0, 5, 0, 0, F_RUN));
        cyc(); start = 1'b0; check_out();
        tick_1sec = 1'b1; push("t1_tick", mk(0, 4, 5, 9, F_RUN));
        cyc(); tick_1sec = 1'b0; check_out();

        // 9 back-to-back strikes drain 90 s: 04:59 -> 03:29
        strike = 1'b1; repeat (9) cyc(); strike = 1'b0;
        push("drain_90", mk(0, 3, 2, 9, F_RUN));
        repeat (100) cyc(); check_out();
        tick_1sec = 1'b1; push("ticks_to_0320", mk(0, 3, 2, 0, F_RUN));
        repeat (9) cyc(); tick_1sec = 1'b0; check_out();

        // Pause freezes digits, ignores ticks and strikes
        pause = 1'b1; push("t4_pause", mk(0, 3, 2, 0, F_NONE));
        cyc(); pause = 1'b0; check_out();
        tick_1sec = 1'b1; strike = 1'b1; push("t4_frozen", mk(0, 3, 2, 0, F_NONE));
        repeat (5) cyc(); tick_1sec = 1'b0; strike = 1'b0; check_out();
        start = 1'b1; push("t4_resume", mk(0, 3, 2, 0, F_RUN));
        cyc(); start = 1'b0; check_out();
        push("t4_no_pend", mk(0, 3, 2, 0, F_RUN));
        repeat (20) cyc(); check_out();
        tick_1sec = 1'b1; push("t4_tick", mk(0, 3, 1, 9, F_RUN));
        cyc(); tick_1sec = 1'b0; check_out();

        // 16 strikes drain 160 s: 03:19 -> 00:39, then ticks to 00:30
        strike = 1'b1; repeat (16) cyc(); strike = 1'b0;
        push("drain_160", mk(0, 0, 3, 9, F_RUN));
        repeat (200) cyc(); check_out();
        tick_1sec = 1'b1; push("to_0030", mk(0, 0, 3, 0, F_RUN));
        repeat (9) cyc(); tick_1sec = 1'b0; check_out();

        // Strike with tick: tick decrements, full penalty then drains
        tick_1sec = 1'b1; strike = 1'b1; push("t6_tick_strike", mk(0, 0, 2, 9, F_RUN));
        cyc(); tick_1sec = 1'b0; strike = 1'b0; check_out();
        push("t6_drain9", mk(0, 0, 2, 0, F_RUN));
        repeat (9) cyc(); check_out();
        push("t6_drain10", mk(0, 0, 1, 9, F_RUN));
        cyc(); check_out();
        push("t6_drain_stop", mk(0, 0, 1, 9, F_RUN));
        repeat (3) cyc(); check_out();

        // Lone strike: no decrement that cycle, then 10 consecutive
        strike = 1'b1; push("t2_strike", mk(0, 0, 1, 9, F_RUN));
        cyc(); strike = 1'b0; check_out();
        push("t2_warn_0010", mk(0, 0, 1, 0, F_RUNW));
        repeat (9) cyc(); check_out();
        push("t2_0009", mk(0, 0, 0, 9, F_RUNW));
        cyc(); check_out();
        push("t2_pend_zero", mk(0, 0, 0, 9, F_RUNW));
        repeat (5) cyc(); check_out();

        // Blink half period of 25 tick_10ms pulses
        tick_10ms = 1'b1; push("t5_blink_24", mk(0, 0, 0, 9, F_RUNW));
        repeat (24) cyc(); check_out();
        push("t5_blink_25", mk(0, 0, 0, 9, F_RUNWB));
        cyc(); check_out();
        push("t5_blink_49", mk(0, 0, 0, 9, F_RUNWB));
        repeat (24) cyc(); check_out();
        push("t5_blink_50", mk(0, 0, 0, 9, F_RUNW));
        cyc(); tick_10ms = 1'b0; check_out();

        // Run out the clock
        tick_1sec = 1'b1; push("t3_0001", mk(0, 0, 0, 1, F_RUNW));
        repeat (8) cyc(); check_out();
        push("t3_expire", mk(0, 0, 0, 0, F_EXP1));
        cyc(); check_out();
        push("t3_pulse_end", mk(0, 0, 0, 0, F_EXP));
        cyc(); check_out();
        start = 1'b1; strike = 1'b1; defuse = 1'b1;
        push("t3_terminal", mk(0, 0, 0, 0, F_EXP));
        repeat (3) cyc(); {tick_1sec, start, strike, defuse} = '0; check_out();

        // Reset mid-drain aborts immediately
        rst = 1'b0; cyc(); rst = 1'b1; cyc();
        start = 1'b1; push("r_start", mk(0, 5, 0, 0, F_RUN));
        cyc(); start = 1'b0; check_out();
        strike = 1'b1; push("r_strike", mk(0, 5, 0, 0, F_RUN));
        cyc(); strike = 1'b0; check_out();
        push("r_drain5", mk(0, 4, 5, 5, F_RUN));
        repeat (5) cyc(); check_out();
        rst = 1'b0; push("r_async", mk(0, 5, 0, 0, F_NONE));
        #1; check_out();
        cyc(); rst = 1'b1;
        start = 1'b1; push("r_restart", mk(0, 5, 0, 0, F_RUN));
        cyc(); start = 1'b0; check_out();
        push("r_pend_cleared", mk(0, 5, 0, 0, F_RUN));
        repeat (3) cyc(); check_out();

        // Defuse beats pause and start in the same cycle
        defuse = 1'b1; pause = 1'b1; start = 1'b1;
        push("defuse_prio", mk(0, 5, 0, 0, F_DEF));
        cyc(); {defuse, pause, start} = '0; check_out();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
